// File: rtl/uproc_pkg.sv
// rtl/uproc_pkg.sv - shared state encoding, opcode field layout and opcode constants
package uproc_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_DEC   = 3'd2,
        S_EXEC  = 3'd3,
        S_MEM   = 3'd4,
        S_WB    = 3'd5
    } state_t;

    localparam int OPCODE_W = 4;

    localparam logic [OPCODE_W-1:0] OP_NOP   = 4'h0;
    localparam logic [OPCODE_W-1:0] OP_ALU   = 4'h1;
    localparam logic [OPCODE_W-1:0] OP_LOAD  = 4'h2;
    localparam logic [OPCODE_W-1:0] OP_STORE = 4'h3;
    localparam logic [OPCODE_W-1:0] OP_CALL  = 4'h4;
    localparam logic [OPCODE_W-1:0] OP_RET   = 4'h5;

endpackage

// File: rtl/ret_stack.sv
// rtl/ret_stack.sv - circular return-address LIFO; a push when full overwrites the oldest entry
module ret_stack #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] top,
    output logic         full,
    output logic         empty
);

    localparam int SPW = $clog2(DEPTH);
    localparam logic [SPW:0] FULL_CNT = (SPW+1)'(DEPTH);

    logic [W-1:0]   mem [DEPTH];
    logic [SPW-1:0] sp;
    logic [SPW-1:0] sp_m1;
    logic [SPW:0]   count;

    assign sp_m1 = sp - 1'b1;
    assign top   = mem[sp_m1];
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    // sp always wraps; count saturates so full/empty stay truthful after overflow/underflow
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp    <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push) begin
            mem[sp] <= din;
            sp      <= sp + 1'b1;
            if (!full) count <= count + 1'b1;
        end else if (pop) begin
            sp <= sp_m1;
            if (!empty) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - fetch/decode/execute control FSM, PC and return stack; STACK_TRAP_EN traps stack faults to pc 0
module instr_sequencer
    import uproc_pkg::*;
#(
    parameter int INSTR_W     = 16,
    parameter int PC_W        = 8,
    parameter int STACK_DEPTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    output logic                imem_req,
    output logic [PC_W-1:0]     imem_addr,
    input  logic                imem_ack,
    input  logic [INSTR_W-1:0]  imem_data,
    output logic [OPCODE_W-1:0] opcode,
    input  logic                dec_rw,
    input  logic                dec_mw,
    input  logic                dec_data,
    input  logic                dec_push,
    input  logic                dec_pop,
    output logic                dmem_req,
    output logic                dmem_we,
    input  logic                dmem_ack,
    output logic                rf_we,
    output logic [PC_W-1:0]     pc,
    output logic                stk_err
);

    state_t              state, state_nxt;
    logic [INSTR_W-1:0]  ir;
    logic [PC_W-1:0]     pc_nxt, pc_inc, target;
    logic                ir_ld, ctl_ld, err_set;
    logic                rw_q, mw_q;
    logic                stk_push, stk_pop, stk_full, stk_empty;
    logic [PC_W-1:0]     stk_top;
    logic                ir_unused;

    assign opcode    = ir[INSTR_W-1 -: OPCODE_W];
    assign target    = ir[PC_W-1:0];
    assign ir_unused = ^ir[INSTR_W-OPCODE_W-1:PC_W];
    assign pc_inc    = pc + 1'b1;

    // Decoder levels are captured in EXEC so every strobe below is a pure register decode
    assign imem_req  = (state == S_FETCH);
    assign imem_addr = pc;
    assign dmem_req  = (state == S_MEM);
    assign dmem_we   = (state == S_MEM) && mw_q;
    assign rf_we     = (state == S_WB) && rw_q;

    ret_stack #(.DEPTH(STACK_DEPTH), .W(PC_W)) u_ret_stack (
        .clk   (clk),
        .reset (reset),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (pc_inc),
        .top   (stk_top),
        .full  (stk_full),
        .empty (stk_empty)
    );

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        ir_ld     = 1'b0;
        ctl_ld    = 1'b0;
        err_set   = 1'b0;
        stk_push  = 1'b0;
        stk_pop   = 1'b0;
        case (state)
            S_IDLE:  state_nxt = S_FETCH;
            S_FETCH: if (imem_ack) begin
                ir_ld     = 1'b1;
                state_nxt = S_DEC;
            end
            S_DEC:   state_nxt = S_EXEC;
            S_EXEC: begin
                ctl_ld = 1'b1;
                if (dec_push) begin
                    err_set   = stk_full;
                    state_nxt = S_FETCH;
`ifdef STACK_TRAP_EN
                    if (stk_full) begin
                        pc_nxt = '0;
                    end else begin
                        stk_push = 1'b1;
                        pc_nxt   = target;
                    end
`else
                    stk_push = 1'b1;
                    pc_nxt   = target;
`endif
                end else if (dec_pop) begin
                    err_set   = stk_empty;
                    state_nxt = S_FETCH;
`ifdef STACK_TRAP_EN
                    if (stk_empty) begin
                        pc_nxt = '0;
                    end else begin
                        stk_pop = 1'b1;
                        pc_nxt  = stk_top;
                    end
`else
                    stk_pop = 1'b1;
                    pc_nxt  = stk_top;
`endif
                end else if (dec_data || dec_mw) begin
                    state_nxt = S_MEM;
                end else begin
                    state_nxt = S_WB;
                end
            end
            S_MEM: if (dmem_ack) begin
                if (rw_q) begin
                    state_nxt = S_WB;
                end else begin
                    pc_nxt    = pc_inc;
                    state_nxt = S_FETCH;
                end
            end
            S_WB: begin
                pc_nxt    = pc_inc;
                state_nxt = S_FETCH;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            pc      <= '0;
            ir      <= '0;
            rw_q    <= 1'b0;
            mw_q    <= 1'b0;
            stk_err <= 1'b0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (ir_ld) ir <= imem_data;
            if (ctl_ld) begin
                rw_q <= dec_rw;
                mw_q <= dec_mw;
            end
            if (err_set) stk_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - directed bench with an instruction-level reference model
module tb_instr_sequencer;
    import uproc_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req, imem_ack = 1'b0;
    logic [7:0]  imem_addr, pc;
    logic [15:0] imem_data = '0;
    logic [3:0]  opcode;
    logic        dec_rw, dec_mw, dec_data, dec_push, dec_pop;
    logic        dmem_req, dmem_we, dmem_ack = 1'b0, rf_we, stk_err;

    instr_sequencer #(.INSTR_W(16), .PC_W(8), .STACK_DEPTH(8)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .opcode(opcode), .dec_rw(dec_rw), .dec_mw(dec_mw), .dec_data(dec_data),
        .dec_push(dec_push), .dec_pop(dec_pop),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .rf_we(rf_we), .pc(pc), .stk_err(stk_err)
    );

    always #5 clk = ~clk;

    assign dec_rw   = (opcode == OP_ALU) || (opcode == OP_LOAD);
    assign dec_mw   = (opcode == OP_STORE);
    assign dec_data = (opcode == OP_LOAD) || (opcode == OP_STORE);
    assign dec_push = (opcode == OP_CALL);
    assign dec_pop  = (opcode == OP_RET);

    logic [15:0] prog [256];
    int iwait = 0, dwait = 0;
    int vecs = 0, misses = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            misses++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ins(input logic [3:0] op, input logic [7:0] tgt);
        return {op, 4'h0, tgt};
    endfunction

    // Memory responders: ack after iwait/dwait extra request cycles
    initial begin
        int iw, dw;
        iw = 0; dw = 0;
        forever begin
            @(posedge clk); #1;
            if (imem_req) begin
                if (iw >= iwait) begin imem_ack = 1'b1; imem_data = prog[imem_addr]; iw = 0; end
                else begin imem_ack = 1'b0; iw++; end
            end else begin imem_ack = 1'b0; iw = 0; end
            if (dmem_req) begin
                if (dw >= dwait) begin dmem_ack = 1'b1; dw = 0; end
                else begin dmem_ack = 1'b0; dw++; end
            end else begin dmem_ack = 1'b0; dw = 0; end
        end
    end

    // Reference model: advances once per accepted fetch, checks each instruction's footprint
    logic [7:0] m_pc;
    bit         m_pc_known, m_err, model_on, have_prev, m_req_q, exp_we;
    logic [7:0] m_stk[$];
    int         exp_lat, exp_rf, exp_dm, cyc, rf_cnt, dm_cnt;

    task automatic model_step();
        logic [15:0] w;
        w = prog[m_pc];
        exp_rf = 0; exp_dm = 0; exp_we = 0; have_prev = 1;
        case (w[15:12])
            OP_ALU:   begin exp_lat = iwait + 4; exp_rf = 1; m_pc = m_pc + 8'd1; end
            OP_LOAD:  begin exp_lat = iwait + 5 + dwait; exp_rf = 1; exp_dm = dwait + 1; m_pc = m_pc + 8'd1; end
            OP_STORE: begin exp_lat = iwait + 4 + dwait; exp_dm = dwait + 1; exp_we = 1; m_pc = m_pc + 8'd1; end
            OP_CALL: begin
                exp_lat = iwait + 3;
                if (m_stk.size() == 8) begin
                    m_err = 1;
`ifdef STACK_TRAP_EN
                    m_pc = 8'd0;
`else
                    void'(m_stk.pop_front());
                    m_stk.push_back(m_pc + 8'd1);
                    m_pc = w[7:0];
`endif
                end else begin
                    m_stk.push_back(m_pc + 8'd1);
                    m_pc = w[7:0];
                end
            end
            OP_RET: begin
                exp_lat = iwait + 3;
                if (m_stk.size() == 0) begin
                    m_err = 1;
`ifdef STACK_TRAP_EN
                    m_pc = 8'd0;
`else
                    m_pc_known = 0;
`endif
                end else m_pc = m_stk.pop_back();
            end
            default: begin exp_lat = iwait + 4; m_pc = m_pc + 8'd1; end
        endcase
    endtask

    always @(negedge clk) begin
        if (model_on && !reset) begin
            if (imem_req && !m_req_q) begin
                if (have_prev) begin
                    chk("latency", cyc, exp_lat);
                    chk("rf_we_pulses", rf_cnt, exp_rf);
                    chk("dmem_cycles", dm_cnt, exp_dm);
                end
                if (m_pc_known) chk("fetch_addr", imem_addr, m_pc);
                chk("stk_err", stk_err, m_err);
                cyc = 1; rf_cnt = 0; dm_cnt = 0;
            end else cyc++;
            if (rf_we) rf_cnt++;
            if (dmem_req) begin dm_cnt++; chk("dmem_we", dmem_we, exp_we); end
            if (imem_req && imem_ack && m_pc_known) model_step();
            m_req_q = imem_req;
        end
    end

    task automatic do_reset();
        model_on = 0;
        reset = 1'b1;
        @(posedge clk); @(posedge clk);
        m_pc = 8'd0; m_pc_known = 1; m_stk.delete(); m_err = 0;
        have_prev = 0; m_req_q = 0; cyc = 0; rf_cnt = 0; dm_cnt = 0;
        #2 reset = 1'b0;
        model_on = 1;
    endtask

    task automatic wait_fetch(output logic [7:0] a, output int cycles, output int rfp,
                              output int dmc, output int wec);
        logic last;
        last = imem_req;
        a = 8'hFF; cycles = 0; rfp = 0; dmc = 0; wec = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            cycles++;
            if (imem_req && !last) begin a = imem_addr; return; end
            if (rf_we) rfp++;
            if (dmem_req) dmc++;
            if (dmem_req && dmem_we) wec++;
            last = imem_req;
        end
        chk("fetch_timeout", 32'd1, 32'd0);
    endtask

    task automatic expect_fetch(input string nm, input logic [7:0] exp_a);
        logic [7:0] a;
        int c, r, d, w;
        wait_fetch(a, c, r, d, w);
        chk(nm, a, exp_a);
    endtask

    initial begin
        logic [7:0] a;
        int c, r, d, w;
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] a;
        int c, r, d, w;
        for (int i = 0; i < 256; i++) prog[i] = ins(OP_NOP, 8'h00);

        // Reset state
        #12;
        chk("rst_imem_req", imem_req, 0); chk("rst_dmem_req", dmem_req, 0);
        chk("rst_dmem_we", dmem_we, 0);   chk("rst_rf_we", rf_we, 0);
        chk("rst_pc", pc, 0);             chk("rst_stk_err", stk_err, 0);
        chk("rst_imem_addr", imem_addr, 0); chk("rst_opcode", opcode, 0);

        // ALU / load / store sequence, zero-wait memories
        prog[0] = ins(OP_ALU, 8'h00);  prog[1] = ins(OP_ALU, 8'h00);
        prog[2] = ins(OP_LOAD, 8'h00); prog[3] = ins(OP_STORE, 8'h00);
        prog[5] = ins(OP_ALU, 8'h00);
        do_reset();
        wait_fetch(a, c, r, d, w);
        chk("t1_first_fetch", a, 8'h00);
        wait_fetch(a, c, r, d, w);
        chk("t1_alu_addr", a, 8'h01); chk("t1_alu_cycles", c, 4); chk("t1_alu_rf", r, 1);
        expect_fetch("t1_addr2", 8'h02);
        wait_fetch(a, c, r, d, w);
        chk("t1_load_cycles", c, 5); chk("t1_load_rf", r, 1); chk("t1_load_dm", d, 1);
        wait_fetch(a, c, r, d, w);
        chk("t1_store_cycles", c, 4); chk("t1_store_rf", r, 0); chk("t1_store_we", w, 1);
        expect_fetch("t1_addr5", 8'h05);
        expect_fetch("t1_addr6", 8'h06);

        // Store with dmem_ack delayed 3 cycles, then load with the same delay
        for (int i = 0; i < 256; i++) prog[i] = ins(OP_NOP, 8'h00);
        prog[0] = ins(OP_STORE, 8'h00); prog[1] = ins(OP_LOAD, 8'h00);
        dwait = 3;
        do_reset();
        expect_fetch("t2_first", 8'h00);
        wait_fetch(a, c, r, d, w);
        chk("t2_store_dm", d, 4); chk("t2_store_we", w, 4);
        chk("t2_store_rf", r, 0); chk("t2_store_cycles", c, 7); chk("t2_store_next", a, 8'h01);
        wait_fetch(a, c, r, d, w);
        chk("t2_load_dm", d, 4); chk("t2_load_we", w, 0);
        chk("t2_load_rf", r, 1); chk("t2_load_cycles", c, 8);
        expect_fetch("t2_addr3", 8'h03);
        dwait = 0;

        // Call at 5 to 0x40, return to 6, then return on the now-empty stack (slow imem)
        for (int i = 0; i < 256; i++) prog[i] = ins(OP_NOP, 8'h00);
        prog[5] = ins(OP_CALL, 8'h40); prog[8'h40] = ins(OP_RET, 8'h00); prog[6] = ins(OP_RET, 8'h00);
        iwait = 2;
        do_reset();
        for (int i = 0; i < 6; i++) expect_fetch("t3_seq", 8'(i));
        wait_fetch(a, c, r, d, w);
        chk("t3_call_target", a, 8'h40); chk("t3_call_cycles", c, 5);
        expect_fetch("t3_return_addr", 8'h06);
        chk("t3_err_before", stk_err, 0);
        wait_fetch(a, c, r, d, w);
        chk("t3_err_after_empty_ret", stk_err, 1);
`ifdef STACK_TRAP_EN
        chk("t3_trap_vector", a, 8'h00);
`endif
        model_on = 0;
        for (int i = 0; i < 20; i++) begin @(negedge clk); chk("t3_err_sticky", stk_err, 1); end
        iwait = 0;
        do_reset();
        @(negedge clk);
        chk("t3_err_cleared", stk_err, 0);

        // Nine nested calls overflow the 8-deep stack
        for (int i = 0; i < 256; i++) prog[i] = ins(OP_NOP, 8'h00);
        for (int k = 0; k < 9; k++) prog[k*16] = ins(OP_CALL, 8'((k+1)*16));
        do_reset();
        for (int k = 0; k < 9; k++) expect_fetch("t4_nest", 8'(k*16));
        chk("t4_err_before", stk_err, 0);
        wait_fetch(a, c, r, d, w);
        chk("t4_err_after", stk_err, 1);
`ifdef STACK_TRAP_EN
        chk("t4_overflow_pc", a, 8'h00);
`else
        chk("t4_overflow_pc", a, 8'h90);
`endif

        // Reset while imem_req is high
        for (int i = 0; i < 256; i++) prog[i] = ins(OP_NOP, 8'h00);
        do_reset();
        for (int i = 0; i < 3; i++) expect_fetch("t5_seq", 8'(i));
        model_on = 0;
        iwait = 5;
        expect_fetch("t5_slow_fetch", 8'h03);
        @(posedge clk); #3 reset = 1'b1;
        #1;
        chk("t5_req_dropped", imem_req, 0); chk("t5_pc_zero", pc, 0);
        @(posedge clk); @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        chk("t5_idle_after_release", imem_req, 0);
        @(negedge clk);
        chk("t5_fetch_after_idle", imem_req, 1);
        chk("t5_fetch_addr", imem_addr, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, misses);
        $finish;
    end

endmodule
